mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: count register width in bits; legal range 2..32.
REQ-002 Parameter MODULUS, default 256: count range is 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable; 1 = step this cycle.
REQ-006 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 count  output  WIDTH  current count, registered.
REQ-010 wrap  output  1  registered one-cycle pulse flagging a boundary event.
REQ-011 ovf  output  1  registered sticky boundary flag.

Function
REQ-012 Priority per edge SHALL be load > en > hold.
REQ-013 load=1: count <= load_val if load_val < MODULUS, else MODULUS-1 (clamp); en and up ignored that cycle.
REQ-014 load=1 SHALL clear ovf and force wrap to 0 on the same edge.
REQ-015 en=1, up=1, count < MODULUS-1: count <= count+1.
REQ-016 en=1, up=1, count == MODULUS-1: boundary event; count <= 0 (wrap mode).
REQ-017 en=1, up=0, count > 0: count <= count-1.
REQ-018 en=1, up=0, count == 0: boundary event; count <= MODULUS-1 (wrap mode).
REQ-019 en=0, load=0: count, ovf hold; wrap <= 0.
REQ-020 wrap SHALL be 1 for exactly the cycle following a boundary-event edge, 0 otherwise; back-to-back boundary events give consecutive pulses.
REQ-021 ovf SHALL set on any boundary event and stay set until load or reset.
REQ-022 Arithmetic SHALL be WIDTH bits with no carry leaking into count; when MODULUS == 2**WIDTH, wrap coincides with natural roll-over.
REQ-023 Direction change SHALL take effect on the same edge as the new up value; no idle cycle.

Reset
REQ-024 reset=0 SHALL immediately, without waiting for clk, force count=0, wrap=0, ovf=0.
REQ-025 Reset asserted mid-count SHALL discard the in-flight step; first step after deassertion starts from 0.
REQ-026 Reset deassertion is synchronised externally; the block does not resynchronise it.

Configuration
REQ-027 Macro MOD_COUNTER_SAT_EN SHALL select saturation.
REQ-028 Defined: a boundary event holds count (MODULUS-1 going up, 0 going down); wrap and ovf still behave per REQ-020/021.
REQ-029 Undefined: wrap-around per REQ-016/018; no saturation logic synthesised.

Structure
REQ-030 Package counter_pkg SHALL hold the default WIDTH/MODULUS constants and the direction encoding constants (DIR_UP=1, DIR_DOWN=0).
REQ-031 Sub-module counter_incdec SHALL be a combinational WIDTH-bit +/-1 unit (inputs a, up; outputs sum, carry) instantiated once; the register, boundary compare and flags live in mod_counter.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-032 Reset, en=1 up=1 for 12 cycles -> count 1..9,0,1,2; wrap=1 only in the cycle count shows 0; ovf=1 from then on.
REQ-033 count=0, en=1 up=0 -> count=9, wrap pulse 1 cycle, ovf=1; next edge count=8, wrap=0.
REQ-034 count=4, load=1 load_val=7 en=1 -> count=7, ovf=0; then load_val=12 -> count=9 (clamped).
REQ-035 count=5, reset driven low between edges -> count=0 before next edge; after release, en=1 up=1 -> count=1.
REQ-036 MOD_COUNTER_SAT_EN defined: count=9, en=1 up=1 -> count stays 9, wrap pulse, ovf=1; count=0 up=0 -> stays 0.
REQ-037 WIDTH=8, MODULUS=256, count=255, en=1 up=1 -> count=0, wrap=1; en=0 for 3 cycles -> count=0, wrap=0, ovf=1.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the modulo counter slice.
//   DEF_WIDTH / DEF_MODULUS : default count register width and modulus
//   DIR_UP / DIR_DOWN       : encoding of the 'up' direction input
// Optional feature macro used by this slice: MOD_COUNTER_SAT_EN
// (saturate at the range ends instead of wrapping).
package counter_pkg;

    localparam int     DEF_WIDTH   = 8;
    localparam longint DEF_MODULUS = 256;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_incdec.sv
// counter_incdec: combinational WIDTH-bit +/-1 unit.
//   a     : operand
//   up    : DIR_UP adds one, DIR_DOWN subtracts one
//   sum   : WIDTH-bit result (natural roll-over)
//   carry : carry out when incrementing, borrow out when decrementing
module counter_incdec
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic             up,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        // The extra top bit captures carry (add) or borrow (subtract),
        // so nothing leaks into the WIDTH-bit result.
        if (up == DIR_UP) begin
            {carry, sum} = {1'b0, a} + ONE;
        end else begin
            {carry, sum} = {1'b0, a} - ONE;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo-MODULUS counter with load, wrap pulse and
// sticky overflow flag.
//   clk      : clock, all state changes on the rising edge
//   reset    : asynchronous active-low reset (clears count, wrap, ovf)
//   en       : step enable
//   up       : direction (DIR_UP = increment, DIR_DOWN = decrement)
//   load     : synchronous load strobe, highest priority
//   load_val : value to load, clamped to MODULUS-1
//   count    : registered count, 0..MODULUS-1
//   wrap     : registered one-cycle pulse after a boundary step
//   ovf      : registered sticky boundary flag, cleared by load or reset
// Macro MOD_COUNTER_SAT_EN: when defined, a boundary step holds the count
// at the range end instead of wrapping; wrap/ovf behave the same.
module mod_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH   = DEF_WIDTH,
    parameter longint MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf
);

    // MODULUS may be 2**WIDTH, so it needs one extra bit.
    localparam logic [WIDTH:0]   MOD_W      = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   MOD_M1     = MOD_W - {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX        = MOD_M1[WIDTH-1:0];
    localparam bit               FULL_RANGE = (MOD_W == {1'b1, {WIDTH{1'b0}}});

    logic [WIDTH-1:0] step_val;
    logic             step_carry;
    logic             at_max;
    logic             at_min;
    logic             boundary;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_count;

    counter_incdec #(.WIDTH(WIDTH)) u_incdec (
        .a     (count),
        .up    (up),
        .sum   (step_val),
        .carry (step_carry)
    );

    assign at_max = (count == MAX);
    assign at_min = (count == '0);

    // With a full-range modulus the range ends are exactly where the
    // incrementer carries/borrows, so the carry is the boundary detect.
    always_comb begin
        if (FULL_RANGE) begin
            boundary = en && step_carry;
        end else begin
            boundary = en && ((up == DIR_UP) ? at_max : at_min);
        end
    end

    assign load_clamped = ({1'b0, load_val} < MOD_W) ? load_val : MAX;

    always_comb begin
        next_count = count;
        if (load) begin
            next_count = load_clamped;
        end else if (en) begin
            if (boundary) begin
`ifdef MOD_COUNTER_SAT_EN
                next_count = count;
`else
                next_count = (up == DIR_UP) ? '0 : MAX;
`endif
            end else begin
                next_count = step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= !load && boundary;
            ovf   <= load ? 1'b0 : (ovf || boundary);
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: self-checking bench for mod_counter.
//   u_dut : WIDTH=4, MODULUS=10 (main vectors, reset, random phase)
//   u_big : WIDTH=8, MODULUS=256 (full-range roll-over)
// Honours MOD_COUNTER_SAT_EN for the expected values.
module tb_mod_counter;

    logic       clk;
    logic       reset;
    logic       en, up, load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       wrap, ovf;

    logic       b_en, b_up, b_load;
    logic [7:0] b_load_val;
    logic [7:0] b_count;
    logic       b_wrap, b_ovf;

    int n_cmp;
    int n_fail;

    // expected {count, wrap, ovf}
    logic [5:0] exp_q[$];
    logic [9:0] big_q[$];

    typedef struct {
        string      name;
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic       up;
        logic [3:0] count;
        logic       wrap;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    // bench-side reference state for the random phase (MODULUS=10)
    logic [3:0] m_count;
    logic       m_ovf;

    mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .ovf      (ovf)
    );

    mod_counter #(.WIDTH(8), .MODULUS(256)) u_big (
        .clk      (clk),
        .reset    (reset),
        .en       (b_en),
        .up       (b_up),
        .load     (b_load),
        .load_val (b_load_val),
        .count    (b_count),
        .wrap     (b_wrap),
        .ovf      (b_ovf)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic check(input string name);
        logic [5:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({count, wrap, ovf} !== e) begin
                n_fail++;
                $display("FAIL %s: got count=%0d wrap=%0b ovf=%0b, want count=%0d wrap=%0b ovf=%0b",
                         name, count, wrap, ovf, e[5:2], e[1], e[0]);
            end
        end
    endtask

    task automatic check_big(input string name);
        logic [9:0] e;
        if (big_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = big_q.pop_front();
            n_cmp++;
            if ({b_count, b_wrap, b_ovf} !== e) begin
                n_fail++;
                $display("FAIL %s: got count=%0d wrap=%0b ovf=%0b, want count=%0d wrap=%0b ovf=%0b",
                         name, b_count, b_wrap, b_ovf, e[9:2], e[1], e[0]);
            end
        end
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, push expectation, sample 1 after rising edge.
    task automatic drive(input string name, input logic ld, input logic [3:0] lv,
                         input logic e_n, input logic u_p, input logic [5:0] exp_v);
        @(negedge clk);
        load     = ld;
        load_val = lv;
        en       = e_n;
        up       = u_p;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic add(input string name, input logic ld, input logic [3:0] lv,
                       input logic e_n, input logic u_p, input logic [3:0] c,
                       input logic w, input logic o);
        vec_t v;
        v.name = name; v.load = ld; v.load_val = lv; v.en = e_n; v.up = u_p;
        v.count = c; v.wrap = w; v.ovf = o;
        vecs.push_back(v);
    endtask

    // reference behaviour for MODULUS=10
    task automatic model_step(input logic ld, input logic [3:0] lv, input logic e_n,
                              input logic u_p, output logic [5:0] exp_v);
        logic w;
        w = 1'b0;
        if (ld) begin
            m_count = (lv < 4'd10) ? lv : 4'd9;
            m_ovf   = 1'b0;
        end else if (e_n) begin
            if (u_p) begin
                if (m_count == 4'd9) begin
                    w = 1'b1;
`ifndef MOD_COUNTER_SAT_EN
                    m_count = 4'd0;
`endif
                end else begin
                    m_count = m_count + 4'd1;
                end
            end else begin
                if (m_count == 4'd0) begin
                    w = 1'b1;
`ifndef MOD_COUNTER_SAT_EN
                    m_count = 4'd9;
`endif
                end else begin
                    m_count = m_count - 4'd1;
                end
            end
            if (w) m_ovf = 1'b1;
        end
        exp_v = {m_count, w, m_ovf};
    endtask

    // ---------------- test ----------------
    initial begin
        logic [5:0] ev;
        n_cmp  = 0;
        n_fail = 0;
        reset = 1'b0;
        en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        b_en = 1'b0; b_up = 1'b0; b_load = 1'b0; b_load_val = '0;

        // vector table, starting from reset state
        for (int i = 1; i <= 9; i++) add("count_up", 0, 0, 1, 1, 4'(i), 0, 0);
`ifndef MOD_COUNTER_SAT_EN
        add("up_wrap",     0, 0, 1, 1, 0, 1, 1);
        add("up_after1",   0, 0, 1, 1, 1, 0, 1);
        add("up_after2",   0, 0, 1, 1, 2, 0, 1);
        add("load0",       1, 0, 0, 0, 0, 0, 0);
        add("down_wrap",   0, 0, 1, 0, 9, 1, 1);
        add("down_next",   0, 0, 1, 0, 8, 0, 1);
        add("load4",       1, 4, 0, 0, 4, 0, 0);
        add("load7_en",    1, 7, 1, 1, 7, 0, 0);
        add("load12_clmp", 1, 12, 0, 0, 9, 0, 0);
        add("hold",        0, 0, 0, 1, 9, 0, 0);
        add("b2b_up",      0, 0, 1, 1, 0, 1, 1);
        add("b2b_down",    0, 0, 1, 0, 9, 1, 1);
        add("b2b_up2",     0, 0, 1, 1, 0, 1, 1);
        add("hold_ovf",    0, 0, 0, 0, 0, 0, 1);
        add("load15_clmp", 1, 15, 1, 0, 9, 0, 0);
`else
        add("sat_up1",     0, 0, 1, 1, 9, 1, 1);
        add("sat_up2",     0, 0, 1, 1, 9, 1, 1);
        add("sat_up3",     0, 0, 1, 1, 9, 1, 1);
        add("load0",       1, 0, 0, 0, 0, 0, 0);
        add("sat_down1",   0, 0, 1, 0, 0, 1, 1);
        add("sat_down2",   0, 0, 1, 0, 0, 1, 1);
        add("load4",       1, 4, 0, 0, 4, 0, 0);
        add("load7_en",    1, 7, 1, 1, 7, 0, 0);
        add("load12_clmp", 1, 12, 0, 0, 9, 0, 0);
        add("hold",        0, 0, 0, 1, 9, 0, 0);
        add("sat_up4",     0, 0, 1, 1, 9, 1, 1);
        add("dir_down",    0, 0, 1, 0, 8, 0, 1);
        add("dir_up",      0, 0, 1, 1, 9, 0, 1);
        add("hold_ovf",    0, 0, 0, 0, 9, 0, 1);
        add("load15_clmp", 1, 15, 1, 0, 9, 0, 0);
`endif

        // reset state
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(6'b0);
        check("reset_state");
        big_q.push_back(10'b0);
        check_big("big_reset_state");
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].name, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].up,
                  {vecs[i].count, vecs[i].wrap, vecs[i].ovf});
        end

        // asynchronous reset mid-count
        drive("load5", 1, 5, 0, 0, {4'd5, 1'b0, 1'b0});
        drive("step6", 0, 0, 1, 1, {4'd6, 1'b0, 1'b0});
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(6'b0);
        check("async_reset");
        drive("reset_held", 0, 0, 1, 1, {4'd0, 1'b0, 1'b0});
        reset = 1'b1;
        drive("after_reset", 0, 0, 1, 1, {4'd1, 1'b0, 1'b0});

        // randomised phase against the reference model
        m_count = 4'd1;
        m_ovf   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            logic       r_ld, r_en, r_up;
            logic [3:0] r_lv;
            r_ld = ($urandom_range(0, 7) == 0);
            r_lv = 4'($urandom_range(0, 15));
            r_en = ($urandom_range(0, 3) != 0);
            r_up = 1'($urandom_range(0, 1));
            model_step(r_ld, r_lv, r_en, r_up, ev);
            drive("random", r_ld, r_lv, r_en, r_up, ev);
        end

        // full-range instance: natural roll-over at 255
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        b_load = 1'b1; b_load_val = 8'd255;
        big_q.push_back({8'd255, 1'b0, 1'b0});
        @(posedge clk); #1; check_big("big_load255");
        @(negedge clk);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
`ifndef MOD_COUNTER_SAT_EN
        big_q.push_back({8'd0, 1'b1, 1'b1});
`else
        big_q.push_back({8'd255, 1'b1, 1'b1});
`endif
        @(posedge clk); #1; check_big("big_rollover");
        @(negedge clk);
        b_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
`ifndef MOD_COUNTER_SAT_EN
            big_q.push_back({8'd0, 1'b0, 1'b1});
`else
            big_q.push_back({8'd255, 1'b0, 1'b1});
`endif
            @(posedge clk); #1; check_big("big_hold");
        end

        if (exp_q.size() != 0 || big_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL leftover: %0d/%0d expectations not consumed, want 0",
                     exp_q.size(), big_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
